// File: rtl/cpu_bus_port_pkg.sv
// Shared widths, inter-CPU message codes and port state encoding for the
// CPU-side dispatcher bus port.
package cpu_bus_port_pkg;

  localparam int ADDR_SIZE = 32;
  localparam int DATA_SIZE = 32;

  // Message codes placed on the data lines when a slot is handed back.
  localparam logic [DATA_SIZE-1:0] CPU_R_START = 32'h0000_0001;
  localparam logic [DATA_SIZE-1:0] CPU_R_END   = 32'h0000_0002;

  typedef enum logic [1:0] {
    CPB_IDLE    = 2'd0,
    CPB_REQ     = 2'd1,
    CPB_WAIT    = 2'd2,
    CPB_RELEASE = 2'd3
  } cpb_state_t;

  // One extra bit so the timer can hold TIMEOUT_CYC-1 and saturate above it.
  function automatic int timer_width(input int cyc);
    return $clog2(cyc) + 1;
  endfunction

endpackage

// File: rtl/cpu_bus_port.sv
// CPU-side end of the shared dispatcher bus: answers a per-CPU grant with one
// memory access, returns the result to the core and hands the slot back.
module cpu_bus_port
  import cpu_bus_port_pkg::*;
#(
  parameter int CPU_INDEX   = 0,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          ext_cpu_index,
  input  logic                 ext_cpu_q,
  input  logic [ADDR_SIZE-1:0] addr_i,
  input  logic [DATA_SIZE-1:0] data_i,
  input  logic                 read_dn,
  input  logic                 write_dn,
  output logic                 read_q,
  output logic                 write_q,
  output logic [ADDR_SIZE-1:0] addr_o,
  output logic                 addr_oe,
  output logic [DATA_SIZE-1:0] data_o,
  output logic                 data_oe,
  output logic                 ext_cpu_e,
  input  logic                 core_req,
  input  logic                 core_we,
  input  logic [ADDR_SIZE-1:0] core_addr,
  input  logic [DATA_SIZE-1:0] core_wdata,
  output logic                 core_ack,
  output logic [DATA_SIZE-1:0] core_rdata,
  output logic [ADDR_SIZE-1:0] ctx_addr,
  output logic                 ctx_valid,
  output logic                 err
);

  localparam int TW = timer_width(TIMEOUT_CYC);

  cpb_state_t           state_reg, state_next;
  logic [ADDR_SIZE-1:0] ctx_addr_reg;
  logic                 ctx_valid_reg;
  logic [ADDR_SIZE-1:0] req_addr_reg;
  logic                 we_reg;
  logic [DATA_SIZE-1:0] core_rdata_reg;
  logic                 core_ack_reg;
  logic [DATA_SIZE-1:0] msg_reg;
  logic [TW-1:0]        timer_reg;
  logic                 err_reg;

  logic grant;
  logic done_hit;
  logic timeout_hit;

  assign grant = ext_cpu_q && (ext_cpu_index == 32'(CPU_INDEX));

  // A done strobe counts only if it is the right type and echoes our address;
  // anything else belongs to another CPU on the shared lines.
  assign done_hit = (state_reg == CPB_WAIT) && (addr_i == req_addr_reg) &&
                    (we_reg ? write_dn : read_dn);

  assign timeout_hit = (state_reg == CPB_WAIT) && !done_hit &&
                       (timer_reg == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_next = state_reg;
    read_q     = 1'b0;
    write_q    = 1'b0;
    addr_o     = '0;
    addr_oe    = 1'b0;
    data_o     = '0;
    data_oe    = 1'b0;
    ext_cpu_e  = 1'b0;
    case (state_reg)
      CPB_IDLE: begin
        if (grant) begin
          state_next = core_req ? CPB_REQ : CPB_RELEASE;
        end
      end
      CPB_REQ: begin
        read_q     = !core_we;
        write_q    = core_we;
        addr_o     = core_addr;
        addr_oe    = 1'b1;
        if (core_we) begin
          data_o  = core_wdata;
          data_oe = 1'b1;
        end
        state_next = CPB_WAIT;
      end
      CPB_WAIT: begin
        if (done_hit || timeout_hit) begin
          state_next = CPB_RELEASE;
        end
      end
      CPB_RELEASE: begin
        ext_cpu_e  = 1'b1;
        data_o     = msg_reg;
        data_oe    = 1'b1;
        state_next = CPB_IDLE;
      end
      default: state_next = CPB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= CPB_IDLE;
      ctx_addr_reg   <= '0;
      ctx_valid_reg  <= 1'b0;
      req_addr_reg   <= '0;
      we_reg         <= 1'b0;
      core_rdata_reg <= '0;
      core_ack_reg   <= 1'b0;
      msg_reg        <= '0;
      timer_reg      <= '0;
      err_reg        <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ctx_valid_reg <= 1'b0;
      core_ack_reg  <= 1'b0;
      case (state_reg)
        CPB_IDLE: begin
          if (grant) begin
            ctx_addr_reg  <= addr_i;
            ctx_valid_reg <= 1'b1;
            if (!core_req) begin
              msg_reg <= CPU_R_START;
            end
          end
        end
        CPB_REQ: begin
          req_addr_reg <= core_addr;
          we_reg       <= core_we;
          timer_reg    <= '0;
        end
        CPB_WAIT: begin
          if (timer_reg != {TW{1'b1}}) begin
            timer_reg <= timer_reg + 1'b1;
          end
          // The ack is registered here so it lines up with the release cycle.
          if (done_hit) begin
            core_ack_reg <= 1'b1;
            msg_reg      <= CPU_R_END;
            if (!we_reg) begin
              core_rdata_reg <= data_i;
            end
          end else if (timeout_hit) begin
            err_reg <= 1'b1;
            msg_reg <= CPU_R_END;
          end
        end
        default: ;
      endcase
    end
  end

  assign core_ack   = core_ack_reg;
  assign core_rdata = core_rdata_reg;
  assign ctx_addr   = ctx_addr_reg;
  assign ctx_valid  = ctx_valid_reg;
  assign err        = err_reg;

endmodule
